// File: rtl/cordic_sched_if.sv
// cordic_sched_if: requester, shared-core and response signals of the cordic scheduler
interface cordic_sched_if #(parameter int WIDTH = 32);
  logic [3:0]         req;
  logic [3:0]         req_mode_op;
  logic [7:0]         req_mode_coord;
  logic [4*WIDTH-1:0] req_x, req_y, req_z;
  logic [3:0]         ack;
  logic               core_enable, core_mode_op;
  logic [1:0]         core_mode_coord;
  logic [WIDTH-1:0]   core_x_in, core_y_in, core_z_in;
  logic [WIDTH-1:0]   core_x_out, core_y_out, core_z_out;
  logic               core_valid;
  logic               rsp_valid, rsp_err, busy;
  logic [1:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_x, rsp_y, rsp_z;
  modport slave (
    input  req, req_mode_op, req_mode_coord, req_x, req_y, req_z,
           core_x_out, core_y_out, core_z_out, core_valid,
    output ack, core_enable, core_mode_op, core_mode_coord, core_x_in, core_y_in, core_z_in,
           rsp_valid, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z, busy
  );
  modport master (
    output req, req_mode_op, req_mode_coord, req_x, req_y, req_z,
           core_x_out, core_y_out, core_z_out, core_valid,
    input  ack, core_enable, core_mode_op, core_mode_coord, core_x_in, core_y_in, core_z_in,
           rsp_valid, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z, busy
  );
endinterface

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one cordic core among four requesters
module cordic_sched #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  cordic_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t           state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d, gnt, idx;
  logic             hit, fin;
  logic [3:0]       ack_q, ack_d;
  logic             core_enable_q, core_enable_d, core_mode_op_q, core_mode_op_d;
  logic [1:0]       core_mode_coord_q, core_mode_coord_d;
  logic [WIDTH-1:0] core_x_in_q, core_x_in_d, core_y_in_q, core_y_in_d, core_z_in_q, core_z_in_d;
  logic [WIDTH-1:0] rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d, rsp_z_q, rsp_z_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, busy_q, busy_d, valid_q, valid_d;
  logic [1:0]       rsp_id_q, rsp_id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  assign fin = bus.core_valid && !valid_q;
  // round-robin pick: scanning distances 4..1 leaves the nearest requester after last_grant
  always_comb begin
    hit = 1'b0;
    gnt = last_grant_q;
    idx = last_grant_q;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant_q + 2'(k);
      if (bus.req[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end
  // next state and next values of every registered output
  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    ack_d             = 4'b0;
    core_enable_d     = 1'b0;
    core_mode_op_d    = core_mode_op_q;
    core_mode_coord_d = core_mode_coord_q;
    core_x_in_d       = core_x_in_q;
    core_y_in_d       = core_y_in_q;
    core_z_in_d       = core_z_in_q;
    rsp_valid_d       = 1'b0;
    rsp_id_d          = rsp_id_q;
    rsp_err_d         = rsp_err_q;
    rsp_x_d           = rsp_x_q;
    rsp_y_d           = rsp_y_q;
    rsp_z_d           = rsp_z_q;
    cnt_d             = cnt_q;
    valid_d           = bus.core_valid;
    case (state_q)
      IDLE: if (hit) begin
        state_d           = LAUNCH;
        last_grant_d      = gnt;
        ack_d             = 4'b0001 << gnt;
        core_enable_d     = 1'b1;
        core_mode_op_d    = bus.req_mode_op[gnt];
        core_mode_coord_d = bus.req_mode_coord[2*gnt +: 2];
        core_x_in_d       = bus.req_x[gnt*WIDTH +: WIDTH];
        core_y_in_d       = bus.req_y[gnt*WIDTH +: WIDTH];
        core_z_in_d       = bus.req_z[gnt*WIDTH +: WIDTH];
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (fin || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = last_grant_q;
          rsp_err_d   = !fin;
          rsp_x_d     = fin ? bus.core_x_out : '0;
          rsp_y_d     = fin ? bus.core_y_out : '0;
          rsp_z_d     = fin ? bus.core_z_out : '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      last_grant_q      <= 2'd3;
      ack_q             <= '0;
      core_enable_q     <= 1'b0;
      core_mode_op_q    <= 1'b0;
      core_mode_coord_q <= '0;
      core_x_in_q       <= '0;
      core_y_in_q       <= '0;
      core_z_in_q       <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_id_q          <= '0;
      rsp_err_q         <= 1'b0;
      rsp_x_q           <= '0;
      rsp_y_q           <= '0;
      rsp_z_q           <= '0;
      busy_q            <= 1'b0;
      valid_q           <= 1'b0;
      cnt_q             <= '0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      ack_q             <= ack_d;
      core_enable_q     <= core_enable_d;
      core_mode_op_q    <= core_mode_op_d;
      core_mode_coord_q <= core_mode_coord_d;
      core_x_in_q       <= core_x_in_d;
      core_y_in_q       <= core_y_in_d;
      core_z_in_q       <= core_z_in_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_id_q          <= rsp_id_d;
      rsp_err_q         <= rsp_err_d;
      rsp_x_q           <= rsp_x_d;
      rsp_y_q           <= rsp_y_d;
      rsp_z_q           <= rsp_z_d;
      busy_q            <= busy_d;
      valid_q           <= valid_d;
      cnt_q             <= cnt_d;
    end
  end
  assign bus.ack             = ack_q;
  assign bus.core_enable     = core_enable_q;
  assign bus.core_mode_op    = core_mode_op_q;
  assign bus.core_mode_coord = core_mode_coord_q;
  assign bus.core_x_in       = core_x_in_q;
  assign bus.core_y_in       = core_y_in_q;
  assign bus.core_z_in       = core_z_in_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.rsp_x           = rsp_x_q;
  assign bus.rsp_y           = rsp_y_q;
  assign bus.rsp_z           = rsp_z_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: scoreboard bench for cordic_sched with a behavioural latency-programmable core
module tb_cordic_sched;
  localparam int W  = 32;
  localparam int TO = 64;
  typedef struct packed {
    logic [1:0]   id;
    logic         err;
    logic [W-1:0] x, y, z;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cordic_sched_if #(.WIDTH(W)) bus ();
  cordic_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  rsp_t         exp_q[$];
  logic [3:0]   ack_exp_q[$];
  int           checks = 0, failures = 0, cyc = 0, ack_cyc = 0, lat_exp = -1, core_lat = 4, ccnt = 0;
  logic         inflight = 1'b0, stuck_hi = 1'b0, tie_lo = 1'b0, cv = 1'b0;
  logic [W-1:0] lx = '0, ly = '0, lz = '0, cx = '0, cy = '0, cz = '0;
  logic [W-1:0] xv[4], yv[4], zv[4];
  logic         opv[4];
  logic [1:0]   cov[4];
  rsp_t         e;
  int           mid;

  // linear rotation model: y += x*z in Q16.16, x passes, z inverted so lanes are distinguishable
  function automatic logic [3*W-1:0] core_fn(logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] z);
    logic signed [63:0] p;
    p = 64'($signed(x)) * 64'($signed(z));
    return {x, y + p[47:16], ~z};
  endfunction

  function automatic rsp_t mk(int id, logic err);
    rsp_t r;
    r.id  = 2'(id);
    r.err = err;
    {r.x, r.y, r.z} = err ? '0 : core_fn(xv[id], yv[id], zv[id]);
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // behavioural core: valid rises core_lat edges after the edge that samples enable
  always @(posedge clk) begin
    if (bus.core_enable) begin
      lx <= bus.core_x_in; ly <= bus.core_y_in; lz <= bus.core_z_in;
      cv <= 1'b0; ccnt <= core_lat;
    end else if (ccnt > 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        cv <= 1'b1;
        {cx, cy, cz} <= core_fn(lx, ly, lz);
      end
    end
  end
  assign bus.core_valid = stuck_hi | (cv & ~tie_lo);
  assign bus.core_x_out = cx;
  assign bus.core_y_out = cy;
  assign bus.core_z_out = cz;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: ack order and launched operands, busy while in flight, responses against scoreboard
  always @(negedge clk) if (!rst) begin
    if (bus.ack != 4'h0) begin
      if (ack_exp_q.size() != 0) check("ack", bus.ack, ack_exp_q.pop_front());
      else check("ack_unexp", bus.ack, 0);
      mid = bus.ack[1] ? 1 : bus.ack[2] ? 2 : bus.ack[3] ? 3 : 0;
      check("en_with_ack", bus.core_enable, 1);
      check("x_in", bus.core_x_in, xv[mid]);
      check("y_in", bus.core_y_in, yv[mid]);
      check("z_in", bus.core_z_in, zv[mid]);
      check("op_in", bus.core_mode_op, opv[mid]);
      check("coord_in", bus.core_mode_coord, cov[mid]);
      ack_cyc  = cyc;
      inflight = 1'b1;
    end else check("en_low", bus.core_enable, 0);
    if (inflight) check("busy", bus.busy, 1);
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexp", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_err", bus.rsp_err, e.err);
        check("rsp_x", bus.rsp_x, e.x);
        check("rsp_y", bus.rsp_y, e.y);
        check("rsp_z", bus.rsp_z, e.z);
      end
      if (lat_exp >= 0) check("ack_to_rsp", cyc - ack_cyc, lat_exp);
      inflight = 1'b0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inflight = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_en"}, bus.core_enable, 0);
    check({tag, "_op"}, bus.core_mode_op, 0);
    check({tag, "_coord"}, bus.core_mode_coord, 0);
    check({tag, "_xin"}, bus.core_x_in, 0);
    check({tag, "_yin"}, bus.core_y_in, 0);
    check({tag, "_zin"}, bus.core_z_in, 0);
    check({tag, "_rv"}, bus.rsp_valid, 0);
    check({tag, "_rid"}, bus.rsp_id, 0);
    check({tag, "_rerr"}, bus.rsp_err, 0);
    check({tag, "_rx"}, bus.rsp_x, 0);
    check({tag, "_ry"}, bus.rsp_y, 0);
    check({tag, "_rz"}, bus.rsp_z, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic wait_ack(int i);
    int got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge clk);
      if (bus.ack[i]) got = 1;
    end
    check("ack_wait", got, 1);
  endtask

  task automatic wait_rsp(int n, int bound);
    int seen = 0;
    for (int k = 0; k < bound && seen < n; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("rsp_wait", seen, n);
  endtask

  task automatic single(int i, int lat, logic err, int lexp, int rel);
    core_lat = lat;
    lat_exp  = lexp;
    exp_q.push_back(mk(i, err));
    ack_exp_q.push_back(4'b0001 << i);
    bus.req[i] = 1'b1;
    wait_ack(i);
    bus.req[i] = 1'b0;
    if (rel > 0) begin
      tick(rel);
      stuck_hi = 1'b0;
    end
    wait_rsp(1, TO + 40);
    tick(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    xv[0] = 32'h0001_0000; yv[0] = 32'h0002_0000; zv[0] = 32'hFFFF_0000; opv[0] = 1'b0; cov[0] = 2'd2;
    xv[1] = 32'h7FFF_FFFF; yv[1] = 32'h8000_0000; zv[1] = 32'h0000_0000; opv[1] = 1'b1; cov[1] = 2'd1;
    xv[2] = 32'h0000_8000; yv[2] = 32'h0000_0000; zv[2] = 32'h0001_8000; opv[2] = 1'b0; cov[2] = 2'd1;
    xv[3] = 32'hDEAD_BEEF; yv[3] = 32'h1234_5678; zv[3] = 32'h0000_4000; opv[3] = 1'b1; cov[3] = 2'd3;
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_x[i*W +: W] = xv[i];
      bus.req_y[i*W +: W] = yv[i];
      bus.req_z[i*W +: W] = zv[i];
      bus.req_mode_op[i] = opv[i];
      bus.req_mode_coord[2*i +: 2] = cov[i];
    end
    tick(3);
    rst = 1'b0;
    chk_zero("reset");
    single(2, 8, 1'b0, 10, 0);
    check("y_half_x_1p5", bus.rsp_y, 32'h0000_C000);
    check("id_hold", bus.rsp_id, 2);
    do_reset();
    core_lat = 3;
    lat_exp  = 5;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(mk(k % 4, 1'b0));
      ack_exp_q.push_back(4'b0001 << (k % 4));
    end
    bus.req = 4'hF;
    wait_rsp(5, 200);
    bus.req = 4'h0;
    tick(2);
    single(1, 18, 1'b0, 20, 0);
    tie_lo = 1'b1;
    single(3, 5, 1'b1, TO + 1, 0);
    tie_lo = 1'b0;
    stuck_hi = 1'b1;
    single(0, 5, 1'b1, TO + 1, 0);
    single(2, 10, 1'b0, 12, 3);
    core_lat = 10;
    lat_exp  = -1;
    exp_q.push_back(mk(0, 1'b0));
    ack_exp_q.push_back(4'b0001);
    bus.req[0] = 1'b1;
    wait_ack(0);
    bus.req[0] = 1'b0;
    tick(4);
    do_reset();
    exp_q.delete();
    tick(12);
    check("late_valid_seen", bus.core_valid, 1);
    chk_zero("abort");
    core_lat = 3;
    lat_exp  = 5;
    exp_q.push_back(mk(0, 1'b0));
    exp_q.push_back(mk(3, 1'b0));
    ack_exp_q.push_back(4'b0001);
    ack_exp_q.push_back(4'b1000);
    bus.req = 4'b1001;
    wait_rsp(2, 100);
    bus.req = 4'h0;
    tick(4);
    check("exp_q_empty", exp_q.size(), 0);
    check("ack_q_empty", ack_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
